// File: rtl/serial_byte_rx.sv
// Receiver for the ALU-result serialiser: synchronises SER_CLK/SER_DAT/SER_EN into CLK,
// rebuilds the frame MSB-first and flags dropped (early-ended or stalled) frames.
module serial_byte_rx #(
    parameter int unsigned     DATA_W      = 8,
    parameter int unsigned     SYNC_STAGES = 2,
    parameter int unsigned     TO_W        = 28,
    parameter logic [TO_W-1:0] TIMEOUT     = 28'd100000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SER_CLK,
    input  logic              SER_DAT,
    input  logic              SER_EN,
    output logic [DATA_W-1:0] DATA_out,
    output logic              VALID,
    output logic              ABORT,
    output logic              BUSY,
    output logic [7:0]        FRAME_CNT
);

    localparam int unsigned CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TIMEOUT - 1'b1;

    typedef enum logic [1:0] {StIdle, StShift, StDrain} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q, en_sync_q;
    logic                   clk_prev_q;
    logic                   rise_q, bit_q;
    logic                   en_s;

    state_t              state_q, state_d;
    logic [DATA_W-2:0]   shift_q, shift_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TO_W-1:0]     to_q, to_d, to_inc;
    logic [DATA_W-1:0]   data_q, data_d, shifted;
    logic                valid_q, valid_d;
    logic                abort_q, abort_d;
    logic [7:0]          frame_q, frame_d;

    assign en_s = en_sync_q[SYNC_STAGES-1];

    // Rise and its data bit are registered together so both paths see equal delay.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            clk_sync_q <= '0;
            dat_sync_q <= '0;
            en_sync_q  <= '0;
            clk_prev_q <= 1'b0;
            rise_q     <= 1'b0;
            bit_q      <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], SER_CLK};
            dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], SER_DAT};
            en_sync_q  <= {en_sync_q[SYNC_STAGES-2:0], SER_EN};
            clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
            rise_q     <= clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
            bit_q      <= dat_sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            abort_q <= 1'b0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            abort_q <= abort_d;
            frame_q <= frame_d;
        end
    end

    assign shifted = {shift_q, bit_q};
    assign to_inc  = (to_q == '1) ? to_q : to_q + 1'b1;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        data_d  = data_q;
        valid_d = 1'b0;
        abort_d = 1'b0;
        frame_d = frame_q;
        unique case (state_q)
            StIdle: begin
                shift_d = '0;
                cnt_d   = '0;
                to_d    = '0;
                if (en_s) begin
                    state_d = StShift;
                    if (rise_q) begin
                        shift_d = shifted[DATA_W-2:0];
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            StShift: begin
                // A final bit wins over a simultaneous enable drop.
                if (rise_q && cnt_q == CNT_LAST) begin
                    data_d  = shifted;
                    valid_d = 1'b1;
                    frame_d = frame_q + 1'b1;
                    to_d    = '0;
                    state_d = StDrain;
                end else if (!en_s) begin
                    abort_d = 1'b1;
                    state_d = StIdle;
                end else if (rise_q) begin
                    shift_d = shifted[DATA_W-2:0];
                    cnt_d   = cnt_q + 1'b1;
                    to_d    = '0;
                end else if (to_inc == TO_LAST) begin
                    to_d    = to_inc;
                    abort_d = 1'b1;
                    state_d = StDrain;
                end else begin
                    to_d = to_inc;
                end
            end
            StDrain: begin
                if (!en_s) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign DATA_out  = data_q;
    assign VALID     = valid_q;
    assign ABORT     = abort_q;
    assign BUSY      = (state_q == StShift);
    assign FRAME_CNT = frame_q;

endmodule
